approx_error_monitor: RTL and testbench

APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

---
 rtl/approx_error_monitor_pkg.sv | 15 +
 rtl/approx_error_monitor_ed_stage.sv | 62 ++++++
 rtl/approx_error_monitor.sv | 139 +++++++++++++
 tb/tb_approx_error_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_error_monitor_pkg.sv
// Shared definitions for the approximate-multiplier error monitor:
// default widths and the run-control FSM encoding.
package approx_error_monitor_pkg;

  localparam int DEF_W     = 10;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_error_monitor_ed_stage.sv
// Two-stage error-distance pipe: stage 1 registers the exact product with the
// sample, stage 2 registers |exact - p| together with the operands.
module approx_error_monitor_ed_stage
  import approx_error_monitor_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [2*W-1:0] p,
  output logic           ed_valid,
  output logic [2*W-1:0] ed,
  output logic [W-1:0]   ed_x,
  output logic [W-1:0]   ed_y
);

  logic           v1;
  logic [2*W-1:0] exact1;
  logic [2*W-1:0] p1;
  logic [W-1:0]   x1;
  logic [W-1:0]   y1;
  logic [2*W-1:0] abs_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      exact1 <= '0;
      p1     <= '0;
      x1     <= '0;
      y1     <= '0;
    end else begin
      v1     <= valid;
      exact1 <= {{W{1'b0}}, x} * {{W{1'b0}}, y};
      p1     <= p;
      x1     <= x;
      y1     <= y;
    end
  end

  // Unsigned magnitude of the difference; never wraps.
  always_comb begin
    abs_diff = (exact1 >= p1) ? (exact1 - p1) : (p1 - exact1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_valid <= 1'b0;
      ed       <= '0;
      ed_x     <= '0;
      ed_y     <= '0;
    end else begin
      ed_valid <= v1;
      ed       <= abs_diff;
      ed_x     <= x1;
      ed_y     <= y1;
    end
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Measurement-run controller: accepts num_samples samples, accumulates error
// statistics from the ed pipe, and pulses done once the pipe has drained.
module approx_error_monitor
  import approx_error_monitor_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = 2*W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_x,
  input  logic [W-1:0]     s_y,
  input  logic [2*W-1:0]   s_p,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     max_x,
  output logic [W-1:0]     max_y,
  output state_t           dbg_state
);

  // Handshake: a sample transfers on every rising edge where s_valid && s_ready;
  // s_ready depends only on FSM state and the accept count, never on s_valid.

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic             drain_cnt;
  logic             done_set;
  logic             accept;
  logic             start_ok;
  logic             last_accept;
  logic             ed_valid;
  logic [2*W-1:0]   ed;
  logic [W-1:0]     ed_x;
  logic [W-1:0]     ed_y;

  assign s_ready     = (state == ST_RUN) && (acc_cnt < n_lat);
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign accept      = s_valid && s_ready;
  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_accept = accept && (acc_cnt == n_lat - CNT_ONE);
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (num_samples == '0) begin
            state_nxt = ST_DONE;
            done_set  = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (last_accept) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt) begin
          state_nxt = ST_DONE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      n_lat     <= '0;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      done      <= done_set;
      drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
      if (start_ok) begin
        n_lat   <= num_samples;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + CNT_ONE;
      end
    end
  end

  approx_error_monitor_ed_stage #(.W(W)) u_ed_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (accept),
    .x        (s_x),
    .y        (s_y),
    .p        (s_p),
    .ed_valid (ed_valid),
    .ed       (ed),
    .ed_x     (ed_x),
    .ed_y     (ed_y)
  );

  // Strict > keeps the first sample that reached the current maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
      max_x     <= '0;
      max_y     <= '0;
    end else if (start_ok) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
      max_x     <= '0;
      max_y     <= '0;
    end else if (ed_valid) begin
      if (ed != '0) err_count <= err_count + CNT_ONE;
      sum_ed <= sum_ed + {{(SUM_W-2*W){1'b0}}, ed};
      if (ed > max_ed) begin
        max_ed <= ed;
        max_x  <= ed_x;
        max_y  <= ed_y;
      end
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed and randomized-gap checks of approx_error_monitor against
// hand-computed results and a small software model.
module tb_approx_error_monitor;
  import approx_error_monitor_pkg::*;

  localparam int W     = 10;
  localparam int CNT_W = 16;
  localparam int SUM_W = 2*W + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W-1:0]     s_x = '0;
  logic [W-1:0]     s_y = '0;
  logic [2*W-1:0]   s_p = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [SUM_W-1:0] sum_ed;
  logic [2*W-1:0]   max_ed;
  logic [W-1:0]     max_x;
  logic [W-1:0]     max_y;
  state_t           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  approx_error_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_x         (s_x),
    .s_y         (s_y),
    .s_p         (s_p),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .max_x       (max_x),
    .max_y       (max_y),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    start       = 1'b0;
  endtask

  task automatic send_sample(input int x, input int y, input int p);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_x     = W'(x);
    s_y     = W'(y);
    s_p     = (2*W)'(p);
    for (int k = 0; k < 50 && !ok; k++) begin
      if (s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout x=%0d y=%0d: accepted=0 required=1", x, y);
    end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        cyc = k;
        break;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
    n_checks++; if (s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b exp 0 0 0", s_ready, busy, done); end
    n_checks++; if (err_count !== '0 || sum_ed !== '0 || max_ed !== '0 || max_x !== '0 || max_y !== '0) begin n_fail++; $display("FAIL reset_results: got err=%0d sum=%0d max=%0d exp all 0", err_count, sum_ed, max_ed); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    do_start(3);
    send_sample(3, 5, 15);
    send_sample(10, 10, 96);
    send_sample(1000, 1000, 999000);
    wait_done(20, cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL basic_done_latency: got %0d exp 2", cyc); end
    n_checks++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL basic_err_count: got %0d exp 2", err_count); end
    n_checks++; if (sum_ed !== 36'd1004) begin n_fail++; $display("FAIL basic_sum_ed: got %0d exp 1004", sum_ed); end
    n_checks++; if (max_ed !== 20'd1000) begin n_fail++; $display("FAIL basic_max_ed: got %0d exp 1000", max_ed); end
    n_checks++; if (max_x !== 10'd1000 || max_y !== 10'd1000) begin n_fail++; $display("FAIL basic_max_xy: got %0d,%0d exp 1000,1000", max_x, max_y); end
    tick();
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b exp 0", done); end
    n_checks++; if (dbg_state !== ST_DONE || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_hold: got state=%0d busy=%b exp %0d 0", dbg_state, busy, ST_DONE); end
    n_checks++; if (sum_ed !== 36'd1004 || err_count !== 16'd2) begin n_fail++; $display("FAIL basic_results_hold: got sum=%0d err=%0d exp 1004 2", sum_ed, err_count); end
  endtask

  task automatic test_zero();
    start       = 1'b1;
    num_samples = '0;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready_pre: got %b exp 0", s_ready); end
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b exp 1", done); end
    n_checks++; if (err_count !== '0 || sum_ed !== '0 || max_ed !== '0 || max_x !== '0 || max_y !== '0) begin n_fail++; $display("FAIL zero_results: got err=%0d sum=%0d max=%0d x=%0d y=%0d exp all 0", err_count, sum_ed, max_ed, max_x, max_y); end
    n_checks++; if (s_ready !== 1'b0 || dbg_state !== ST_DONE) begin n_fail++; $display("FAIL zero_state: got ready=%b state=%0d exp 0 %0d", s_ready, dbg_state, ST_DONE); end
    tick();
    n_checks++; if (done !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL zero_after: got done=%b ready=%b exp 0 0", done, s_ready); end
  endtask

  task automatic test_ties();
    int cyc;
    do_start(2);
    send_sample(2, 2, 3);
    send_sample(4, 1, 5);
    wait_done(20, cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL ties_done_latency: got %0d exp 2", cyc); end
    n_checks++; if (max_ed !== 20'd1) begin n_fail++; $display("FAIL ties_max_ed: got %0d exp 1", max_ed); end
    n_checks++; if (max_x !== 10'd2 || max_y !== 10'd2) begin n_fail++; $display("FAIL ties_max_xy: got %0d,%0d exp 2,2", max_x, max_y); end
    n_checks++; if (err_count !== 16'd2 || sum_ed !== 36'd2) begin n_fail++; $display("FAIL ties_err_sum: got err=%0d sum=%0d exp 2 2", err_count, sum_ed); end
  endtask

  task automatic test_back_to_back();
    do_start(4);
    s_valid = 1'b1;
    s_x     = 10'd1023;
    s_y     = 10'd1023;
    s_p     = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b exp 1", k, s_ready); end
      tick();
    end
    s_valid = 1'b0;
    n_checks++; if (s_ready !== 1'b0 || busy !== 1'b1 || dbg_state !== ST_DRAIN) begin n_fail++; $display("FAIL b2b_drain_entry: got ready=%b busy=%b state=%0d exp 0 1 %0d", s_ready, busy, dbg_state, ST_DRAIN); end
    tick();
    n_checks++; if (done !== 1'b0 || dbg_state !== ST_DRAIN) begin n_fail++; $display("FAIL b2b_drain_2nd: got done=%b state=%0d exp 0 %0d", done, dbg_state, ST_DRAIN); end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got done=%b busy=%b exp 1 0", done, busy); end
    n_checks++; if (sum_ed !== 36'd4186116) begin n_fail++; $display("FAIL b2b_sum_ed: got %0d exp 4186116", sum_ed); end
    n_checks++; if (max_ed !== 20'd1046529 || err_count !== 16'd4) begin n_fail++; $display("FAIL b2b_max_err: got max=%0d err=%0d exp 1046529 4", max_ed, err_count); end
    n_checks++; if (max_x !== 10'd1023 || max_y !== 10'd1023) begin n_fail++; $display("FAIL b2b_max_xy: got %0d,%0d exp 1023,1023", max_x, max_y); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int done_seen;
    do_start(5);
    send_sample(3, 3, 0);
    send_sample(2, 2, 5);
    tick();
    tick();
    n_checks++; if (err_count !== 16'd2 || sum_ed !== 36'd10) begin n_fail++; $display("FAIL midrst_pre: got err=%0d sum=%0d exp 2 10", err_count, sum_ed); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (err_count !== '0 || sum_ed !== '0 || max_ed !== '0 || max_x !== '0 || max_y !== '0) begin n_fail++; $display("FAIL midrst_results: got err=%0d sum=%0d max=%0d exp all 0", err_count, sum_ed, max_ed); end
    n_checks++; if (dbg_state !== ST_IDLE || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got state=%0d ready=%b busy=%b done=%b exp %0d 0 0 0", dbg_state, s_ready, busy, done, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) done_seen++;
    end
    n_checks++; if (done_seen != 0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_no_done: got done_pulses=%0d state=%0d exp 0 %0d", done_seen, dbg_state, ST_IDLE); end
    do_start(1);
    send_sample(5, 5, 20);
    wait_done(20, cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL midrst_rerun_latency: got %0d exp 2", cyc); end
    n_checks++; if (err_count !== 16'd1 || sum_ed !== 36'd5 || max_ed !== 20'd5) begin n_fail++; $display("FAIL midrst_rerun: got err=%0d sum=%0d max=%0d exp 1 5 5", err_count, sum_ed, max_ed); end
    n_checks++; if (max_x !== 10'd5 || max_y !== 10'd5) begin n_fail++; $display("FAIL midrst_rerun_xy: got %0d,%0d exp 5,5", max_x, max_y); end
  endtask

  task automatic test_random();
    int     cyc;
    int     x, y, p, exact, ed, mode, gap;
    int     exp_err, exp_max, exp_mx, exp_my;
    longint exp_sum;
    exp_err = 0; exp_max = 0; exp_mx = 0; exp_my = 0; exp_sum = 0;
    do_start(50);
    for (int i = 0; i < 50; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      if (i == 10 || i == 25 || i == 40) begin
        start       = 1'b1;
        num_samples = 16'd3;
        tick();
        start       = 1'b0;
      end
      x     = $urandom_range(0, 1023);
      y     = $urandom_range(0, 1023);
      exact = x * y;
      mode  = $urandom_range(0, 2);
      if (mode == 0)      p = exact;
      else if (mode == 1) p = exact + $urandom_range(1, 20);
      else                p = (exact >= 20) ? exact - $urandom_range(1, 20) : 0;
      ed = (exact >= p) ? exact - p : p - exact;
      if (ed != 0) exp_err++;
      exp_sum += ed;
      if (ed > exp_max) begin exp_max = ed; exp_mx = x; exp_my = y; end
      send_sample(x, y, p);
    end
    wait_done(20, cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL rand_done_latency: got %0d exp 2", cyc); end
    n_checks++; if (err_count !== CNT_W'(exp_err)) begin n_fail++; $display("FAIL rand_err_count: got %0d exp %0d", err_count, exp_err); end
    n_checks++; if (sum_ed !== SUM_W'(exp_sum)) begin n_fail++; $display("FAIL rand_sum_ed: got %0d exp %0d", sum_ed, exp_sum); end
    n_checks++; if (max_ed !== (2*W)'(exp_max)) begin n_fail++; $display("FAIL rand_max_ed: got %0d exp %0d", max_ed, exp_max); end
    n_checks++; if (max_x !== W'(exp_mx) || max_y !== W'(exp_my)) begin n_fail++; $display("FAIL rand_max_xy: got %0d,%0d exp %0d,%0d", max_x, max_y, exp_mx, exp_my); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_ties();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
